// File: rtl/universal_shift_engine.sv
// universal_shift_engine: multi-cycle load/shift/rotate register moving up to STEP bits per cycle
// Ports: clk, rst_n (async active-low); command handshake cmd_valid/cmd_ready with cmd_op, cmd_amt,
// load_data, fill_in; q and shift_out hold the register and last bit shifted out; busy while
// shifting; done pulses one cycle per accepted command.
// Optional SHIFT_ABORT_EN: adds input abort and output aborted to cut a running shift short.
module universal_shift_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int STEP = 1,
  localparam int SHAMT_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [SHAMT_W-1:0]    cmd_amt,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  fill_in,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  shift_out,
  output logic                  busy,
  output logic                  done
`ifdef SHIFT_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  aborted
`endif
);
  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SLL = 3'd1;
  localparam logic [2:0] OP_SRL = 3'd2;
  localparam logic [2:0] OP_SRA = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;
  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);
  localparam logic [SHAMT_W:0] W_C = (SHAMT_W+1)'(DATA_WIDTH);
  localparam logic [SHAMT_W:0] ONE = (SHAMT_W+1)'(1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                  state_q;
  logic [SHAMT_W-1:0]      rem_q, rem_d, step_s;
  logic [2:0]              op_q;
  logic                    fill_q, so_q, so_d, done_q;
  logic [DATA_WIDTH-1:0]   q_q, q_d, lo_mask, hi_mask, lo_v, hi_v;
  logic [SHAMT_W:0]        sx;
`ifdef SHIFT_ABORT_EN
  logic                    aborted_q;
  assign aborted = aborted_q;
`endif
  // One step of s bits; lo_v/hi_v expose the outgoing bit at q[s-1] and q[W-s],
  // and hi_v doubles as the wrapped-around part for rotate-left.
  always_comb begin
    step_s  = (rem_q < STEP_C) ? rem_q : STEP_C;
    sx      = {1'b0, step_s};
    rem_d   = rem_q - step_s;
    lo_mask = ~({DATA_WIDTH{1'b1}} << step_s);
    hi_mask = ~({DATA_WIDTH{1'b1}} >> step_s);
    lo_v    = q_q >> (sx - ONE);
    hi_v    = q_q >> (W_C - sx);
    q_d     = op_q == OP_SLL ? (q_q << step_s) | ({DATA_WIDTH{fill_q}} & lo_mask) :
              op_q == OP_SRL ? (q_q >> step_s) | ({DATA_WIDTH{fill_q}} & hi_mask) :
              op_q == OP_SRA ? (q_q >> step_s) | ({DATA_WIDTH{q_q[DATA_WIDTH-1]}} & hi_mask) :
              op_q == OP_ROL ? (q_q << step_s) | hi_v :
                               (q_q >> step_s) | (q_q << (W_C - sx));
    so_d    = (op_q == OP_SLL || op_q == OP_ROL) ? hi_v[0] : lo_v[0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      op_q    <= '0;
      fill_q  <= 1'b0;
      q_q     <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SHIFT_ABORT_EN
      aborted_q <= 1'b0;
`endif
      if (state_q == IDLE) begin
        if (cmd_valid) begin
          op_q   <= cmd_op;
          fill_q <= fill_in;
          rem_q  <= cmd_amt;
          if (cmd_op == OP_LOAD) q_q <= load_data;
          // only a real shift op with a nonzero amount leaves IDLE
          if (cmd_op != OP_LOAD && cmd_op < 3'd6 && cmd_amt != '0) state_q <= SHIFT;
          else done_q <= 1'b1;
        end
      end
`ifdef SHIFT_ABORT_EN
      else if (abort) begin
        state_q   <= IDLE;
        rem_q     <= '0;
        done_q    <= 1'b1;
        aborted_q <= 1'b1;
      end
`endif
      else begin
        q_q   <= q_d;
        so_q  <= so_d;
        rem_q <= rem_d;
        if (rem_d == '0) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      end
    end
  end
  assign q         = q_q;
  assign shift_out = so_q;
  assign done      = done_q;
  assign busy      = state_q == SHIFT;
  assign cmd_ready = state_q == IDLE;
endmodule

// File: tb/tb_universal_shift_engine.sv
// tb_universal_shift_engine: directed checks of an 8-bit engine at STEP=1 (u1) and STEP=4 (u4)
module tb_universal_shift_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       v1 = 0, v4 = 0, f1 = 0, f4 = 0;
  logic [2:0] op1 = 0, op4 = 0, amt1 = 0, amt4 = 0;
  logic [7:0] ld1 = 0, ld4 = 0;
  logic       r1, r4, so1, so4, b1, b4, d1, d4;
  logic [7:0] q1, q4;
`ifdef SHIFT_ABORT_EN
  logic ab1 = 0, abd1, abd4;
`endif
  int checks = 0, errors = 0;
  universal_shift_engine #(.DATA_WIDTH(8), .STEP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(r1), .cmd_op(op1), .cmd_amt(amt1),
    .load_data(ld1), .fill_in(f1), .q(q1), .shift_out(so1), .busy(b1), .done(d1)
`ifdef SHIFT_ABORT_EN
    , .abort(ab1), .aborted(abd1)
`endif
  );
  universal_shift_engine #(.DATA_WIDTH(8), .STEP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v4), .cmd_ready(r4), .cmd_op(op4), .cmd_amt(amt4),
    .load_data(ld4), .fill_in(f4), .q(q4), .shift_out(so4), .busy(b4), .done(d4)
`ifdef SHIFT_ABORT_EN
    , .abort(1'b0), .aborted(abd4)
`endif
  );
  task automatic issue1(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] d, input logic f);
    @(negedge clk);
    v1 = 1; op1 = op; amt1 = amt; ld1 = d; f1 = f;
    @(posedge clk);
    #1 v1 = 0;
  endtask
  task automatic issue4(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] d, input logic f);
    @(negedge clk);
    v4 = 1; op4 = op; amt4 = amt; ld4 = d; f4 = f;
    @(posedge clk);
    #1 v4 = 0;
  endtask
  // counts negedges after the accept edge until done; cyc=-1 when the budget expires
  task automatic wait1(output int cyc, output int bz);
    logic hit = 0;
    cyc = 0; bz = 0;
    while (!hit && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (b1) bz++;
      hit = d1;
    end
    if (!hit) cyc = -1;
  endtask
  task automatic wait4(output int cyc, output int bz);
    logic hit = 0;
    cyc = 0; bz = 0;
    while (!hit && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (b4) bz++;
      hit = d4;
    end
    if (!hit) cyc = -1;
  endtask
  task automatic test_reset;
    #12;
    checks++;
    if (q1 !== 8'h00 || so1 !== 1'b0 || b1 !== 1'b0 || d1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: q=%h so=%b busy=%b done=%b, want 00 0 0 0", q1, so1, b1, d1);
    end
    @(negedge clk) rst_n = 1;
    #1 checks++;
    if (r1 !== 1'b1 || r4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready1=%b ready4=%b, want 1 1", r1, r4);
    end
  endtask
  task automatic test_sll;
    int c, b;
    issue1(3'd0, 3'd0, 8'hA5, 1'b0);
    wait1(c, b);
    checks++;
    if (c !== 1 || q1 !== 8'hA5) begin
      errors++;
      $display("FAIL load_a5: cyc=%0d q=%h, want 1 a5", c, q1);
    end
    issue1(3'd1, 3'd3, 8'h00, 1'b1);
    wait1(c, b);
    checks++;
    if (c !== 4 || b !== 3) begin
      errors++;
      $display("FAIL sll_timing: done_cyc=%0d busy_cyc=%0d, want 4 3", c, b);
    end
    checks++;
    if (q1 !== 8'h2F || so1 !== 1'b1) begin
      errors++;
      $display("FAIL sll_result: q=%h so=%b, want 2f 1", q1, so1);
    end
  endtask
  task automatic test_sra;
    int c, b;
    issue1(3'd0, 3'd0, 8'h96, 1'b0);
    wait1(c, b);
    issue1(3'd3, 3'd2, 8'h00, 1'b0);
    wait1(c, b);
    checks++;
    if (c !== 3 || q1 !== 8'hE5 || so1 !== 1'b1) begin
      errors++;
      $display("FAIL sra: cyc=%0d q=%h so=%b, want 3 e5 1", c, q1, so1);
    end
  endtask
  task automatic test_nop;
    int c, b;
    issue1(3'd6, 3'd3, 8'h00, 1'b0);
    wait1(c, b);
    checks++;
    if (c !== 1 || b !== 0 || q1 !== 8'hE5 || so1 !== 1'b1) begin
      errors++;
      $display("FAIL nop: cyc=%0d busy=%0d q=%h so=%b, want 1 0 e5 1", c, b, q1, so1);
    end
    issue1(3'd2, 3'd0, 8'h00, 1'b0);
    wait1(c, b);
    checks++;
    if (c !== 1 || b !== 0 || q1 !== 8'hE5) begin
      errors++;
      $display("FAIL amt_zero: cyc=%0d busy=%0d q=%h, want 1 0 e5", c, b, q1);
    end
  endtask
  task automatic test_step4;
    int c, b;
    issue4(3'd0, 3'd0, 8'h81, 1'b0);
    wait4(c, b);
    issue4(3'd5, 3'd7, 8'h00, 1'b0);
    wait4(c, b);
    checks++;
    if (c !== 3 || b !== 2 || q4 !== 8'h03 || so4 !== 1'b0) begin
      errors++;
      $display("FAIL ror7_step4: cyc=%0d busy=%0d q=%h so=%b, want 3 2 03 0", c, b, q4, so4);
    end
    issue4(3'd1, 3'd6, 8'h00, 1'b1);
    wait4(c, b);
    checks++;
    if (c !== 3 || q4 !== 8'hFF || so4 !== 1'b0) begin
      errors++;
      $display("FAIL sll6_step4: cyc=%0d q=%h so=%b, want 3 ff 0", c, q4, so4);
    end
    issue4(3'd2, 3'd5, 8'h00, 1'b0);
    wait4(c, b);
    checks++;
    if (c !== 3 || q4 !== 8'h07 || so4 !== 1'b1) begin
      errors++;
      $display("FAIL srl5_step4: cyc=%0d q=%h so=%b, want 3 07 1", c, q4, so4);
    end
  endtask
  task automatic test_back_to_back;
    int c, b, nr = 0, n = 0;
    issue1(3'd0, 3'd0, 8'h5A, 1'b0);
    wait1(c, b);
    @(negedge clk);
    v1 = 1; op1 = 3'd1; amt1 = 3'd5; f1 = 1'b0;
    @(posedge clk);
    #1 op1 = 3'd2; amt1 = 3'd1; f1 = 1'b1;
    while (!d1 && n < 32) begin
      @(negedge clk);
      n++;
      if (!r1) nr++;
    end
    checks++;
    if (nr !== 5 || d1 !== 1'b1 || r1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall: not_ready=%0d done=%b ready=%b, want 5 1 1", nr, d1, r1);
    end
    checks++;
    if (q1 !== 8'h40 || so1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: q=%h so=%b, want 40 1", q1, so1);
    end
    @(posedge clk);
    #1 v1 = 0;
    wait1(c, b);
    checks++;
    if (c !== 2 || q1 !== 8'hA0 || so1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: cyc=%0d q=%h so=%b, want 2 a0 0", c, q1, so1);
    end
  endtask
  task automatic test_async_reset;
    int c, b;
    issue1(3'd0, 3'd0, 8'hFF, 1'b0);
    wait1(c, b);
    issue1(3'd1, 3'd5, 8'h00, 1'b0);
    @(posedge clk);
    #2 rst_n = 0;
    #1 checks++;
    if (q1 !== 8'h00 || b1 !== 1'b0 || d1 !== 1'b0 || so1 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: q=%h busy=%b done=%b so=%b, want 00 0 0 0", q1, b1, d1, so1);
    end
    @(negedge clk) rst_n = 1;
    #1 checks++;
    if (r1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: ready=%b, want 1", r1);
    end
    issue1(3'd0, 3'd0, 8'h3C, 1'b0);
    wait1(c, b);
    checks++;
    if (c !== 1 || q1 !== 8'h3C) begin
      errors++;
      $display("FAIL load_after_reset: cyc=%0d q=%h, want 1 3c", c, q1);
    end
  endtask
`ifdef SHIFT_ABORT_EN
  task automatic test_abort;
    int c, b;
    issue1(3'd0, 3'd0, 8'hFF, 1'b0);
    wait1(c, b);
    issue1(3'd2, 3'd6, 8'h00, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 ab1 = 1;
    @(posedge clk);
    #1 ab1 = 0;
    @(negedge clk);
    checks++;
    if (d1 !== 1'b1 || abd1 !== 1'b1 || q1 !== 8'h3F || r1 !== 1'b1) begin
      errors++;
      $display("FAIL abort: done=%b aborted=%b q=%h ready=%b, want 1 1 3f 1", d1, abd1, q1, r1);
    end
    @(negedge clk);
    checks++;
    if (d1 !== 1'b0 || abd1 !== 1'b0 || b1 !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse: done=%b aborted=%b busy=%b, want 0 0 0", d1, abd1, b1);
    end
  endtask
`endif
  initial begin
    test_reset;
    test_sll;
    test_sra;
    test_nop;
    test_step4;
    test_back_to_back;
    test_async_reset;
`ifdef SHIFT_ABORT_EN
    test_abort;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
